// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared constants for the RAM arbiter.
// Contents: RV32I load/store funct3 codes, arbiter FSM state encoding,
//           and requester port indices (IF = 0, LS = 1).
package rv32i_mem_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_e;
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane steering, load extension and access checks.
// Ports: we_i/funct3_i/addr_i/wdata_i describe the access, rdata_i is the raw
//        RAM word; wen_o/wdata_o go to the RAM, rdata_o is the extended load
//        value (0 for stores and errors), err_o flags misaligned/illegal/out-of-range.
module mem_align
   import rv32i_mem_pkg::*;
#(
   parameter int RAM_DEPTH = 128
) (
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wen_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   logic [1:0]  off;
   logic        mis, ill, oor;
   logic [31:0] sh;
   always_comb begin
      off = addr_i[1:0];
      // funct3[1:0] encodes the access size for both loads and stores
      mis = (funct3_i[1:0] == 2'b01 && off[0]) || (funct3_i[1:0] == 2'b10 && off != 2'b00);
      ill = we_i ? (funct3_i > F3_SW) : (funct3_i[1:0] == 2'b11 || funct3_i == 3'b110);
      oor = addr_i >= 32'(RAM_DEPTH * 4);
      err_o = mis | ill | oor;
      wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
      wen_o = (!we_i || err_o)           ? 4'b0000 :
              funct3_i[1:0] == 2'b00     ? 4'b0001 << off :
              funct3_i[1:0] == 2'b01     ? 4'b0011 << off : 4'b1111;
      sh = rdata_i >> {off, 3'b000};
      rdata_o = (we_i || err_o)    ? 32'h0 :
                funct3_i == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
                funct3_i == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
                funct3_i == F3_LBU ? {24'h0, sh[7:0]} :
                funct3_i == F3_LHU ? {16'h0, sh[15:0]} : rdata_i;
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of a single-port RAM between fetch and load/store.
// Ports: clk_i/rst_i (sync, active-high); IF port if_req_i/if_addr_i in,
//        if_gnt_o/if_rvalid_o/if_rdata_o/if_err_o out; LS port ls_req_i/ls_we_i/
//        ls_funct3_i/ls_addr_i/ls_wdata_i in, ls_gnt_o/ls_rvalid_o/ls_rdata_o/
//        ls_err_o out; RAM side ram_addr_o/ram_wdata_o/ram_wen_o out, ram_rdata_i in.
module ram_arbiter
   import rv32i_mem_pkg::*;
#(
   parameter int RAM_DEPTH = 128
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [2:0]  ls_funct3_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic        ls_err_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   output logic [3:0]  ram_wen_o,
   input  logic [31:0] ram_rdata_i
);
   state_e      state_q, state_d;
   logic        last_q, last_d, port_q, port_d, we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]  al_wen;
   logic [31:0] al_wdata, al_rdata;
   logic        al_err;

   mem_align #(.RAM_DEPTH(RAM_DEPTH)) u_align (
      .we_i    (we_q),
      .funct3_i(f3_q),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_i (ram_rdata_i),
      .wen_o   (al_wen),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata),
      .err_o   (al_err)
   );

   always_comb begin
      state_d = state_q;
      last_d = last_q;
      port_d = port_q;
      we_d = we_q;
      f3_d = f3_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      if_gnt_o = 1'b0;
      ls_gnt_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if_gnt_o = if_req_i & (~ls_req_i | (last_q == PORT_LS));
            ls_gnt_o = ls_req_i & ~if_gnt_o;
            if (if_gnt_o | ls_gnt_o) begin
               state_d = ST_ACCESS;
               port_d = ls_gnt_o;
               last_d = ls_gnt_o;
               // a fetch is captured as an aligned word load
               we_d = ls_gnt_o & ls_we_i;
               f3_d = ls_gnt_o ? ls_funct3_i : F3_LW;
               addr_d = ls_gnt_o ? ls_addr_i : if_addr_i;
               wdata_d = ls_gnt_o ? ls_wdata_i : 32'h0;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         last_q <= PORT_LS;
         port_q <= PORT_IF;
         we_q <= 1'b0;
         f3_q <= 3'b000;
         addr_q <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         port_q <= port_d;
         we_q <= we_d;
         f3_q <= f3_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // address/data come straight from the capture registers, so they hold between transactions
   assign ram_addr_o = {addr_q[31:2], 2'b00};
   assign ram_wdata_o = al_wdata;
   // gating with rst_i keeps a write from landing when reset hits during ACCESS
   assign ram_wen_o = (state_q == ST_ACCESS && !rst_i) ? al_wen : 4'b0000;
   assign if_rvalid_o = state_q == ST_RESP && port_q == PORT_IF;
   assign ls_rvalid_o = state_q == ST_RESP && port_q == PORT_LS;
   assign if_rdata_o = if_rvalid_o ? al_rdata : 32'h0;
   assign ls_rdata_o = ls_rvalid_o ? al_rdata : 32'h0;
   assign if_err_o = if_rvalid_o & al_err;
   assign ls_err_o = ls_rvalid_o & al_err;
endmodule
